// File: rtl/game_pkg.sv
// Shared codes and the default arena layout for the bomb game blocks.
package game_pkg;

  localparam int unsigned GRID_W = 16;
  localparam int unsigned CELLS  = GRID_W * GRID_W;
  localparam int unsigned IDX_W  = 8;

  localparam logic [IDX_W-1:0] P1_SPAWN = 8'd17;
  localparam logic [IDX_W-1:0] P2_SPAWN = 8'd238;
  localparam logic [IDX_W-1:0] ROW_STEP = IDX_W'(GRID_W);

  typedef enum logic [1:0] {
    EMPTY_WALL  = 2'd0,
    ABLE_WALL   = 2'd1,
    UNABLE_WALL = 2'd2
  } wall_e;

  typedef enum logic [1:0] {
    NOT_OVER  = 2'd0,
    GAME_OVER = 2'd1,
    P1_WIN    = 2'd2,
    P2_WIN    = 2'd3
  } status_e;

  // Spawn clearances win over the pillar pattern so both players start on open floor.
  function automatic wall_e default_wall(input logic [IDX_W-1:0] idx);
    logic [3:0] r;
    logic [3:0] c;
    r = idx[7:4];
    c = idx[3:0];
    if (idx == P1_SPAWN || idx == P1_SPAWN + 8'd1 || idx == P1_SPAWN + ROW_STEP ||
        idx == P2_SPAWN || idx == P2_SPAWN - 8'd1 || idx == P2_SPAWN - ROW_STEP)
      return EMPTY_WALL;
    if (r == 4'd0 || r == 4'd15 || c == 4'd0 || c == 4'd15 || (!r[0] && !c[0]))
      return UNABLE_WALL;
    return ABLE_WALL;
  endfunction

endpackage

// File: rtl/blast_resolver_if.sv
// Bomb-engine/renderer side bundle of the blast resolver.
interface blast_resolver_if;
  import game_pkg::*;

  logic                        restart_i;
  logic [CELLS-1:0]            explode_i;
  logic [IDX_W-1:0]            p1_cor_i;
  logic [IDX_W-1:0]            p2_cor_i;
  logic [CELLS-1:0][1:0]       wall_grid_o;
  logic [CELLS-1:0]            powerup_grid_o;
  logic [1:0]                  p1_bomb_len_o;
  logic [1:0]                  p2_bomb_len_o;
  logic [1:0]                  p1_lives_o;
  logic [1:0]                  p2_lives_o;
  logic                        p1_invuln_o;
  logic                        p2_invuln_o;
  logic [1:0]                  game_status_o;

  modport master (
    output restart_i, explode_i, p1_cor_i, p2_cor_i,
    input  wall_grid_o, powerup_grid_o, p1_bomb_len_o, p2_bomb_len_o,
           p1_lives_o, p2_lives_o, p1_invuln_o, p2_invuln_o, game_status_o
  );

  modport slave (
    input  restart_i, explode_i, p1_cor_i, p2_cor_i,
    output wall_grid_o, powerup_grid_o, p1_bomb_len_o, p2_bomb_len_o,
           p1_lives_o, p2_lives_o, p1_invuln_o, p2_invuln_o, game_status_o
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing every tick; seed must be nonzero.
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_d;

  always_comb begin
    q_d = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    if (load) q_d = seed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= seed;
    else       q <= q_d;
  end

endmodule

// File: rtl/blast_resolver.sv
// Resolves explode grids into wall destruction, power-up drops/pickups, player hits and game status.
module blast_resolver
  import game_pkg::*;
#(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned INVULN_TICKS = 60,
  parameter logic [1:0]  DROP_MASK    = 2'b11,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input logic             clk,
  input logic             reset,
  blast_resolver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(INVULN_TICKS + 1);

  function automatic logic [CELLS-1:0][1:0] init_walls();
    logic [CELLS-1:0][1:0] g;
    for (int i = 0; i < CELLS; i++) g[i] = default_wall(IDX_W'(i));
    return g;
  endfunction

  localparam logic [CELLS-1:0][1:0] WALL_INIT = init_walls();

  logic [CELLS-1:0][1:0]  wall_q, wall_d;
  logic [CELLS-1:0]       pu_q, pu_d;
  logic [CELLS-1:0]       prev_q, prev_d;
  logic [CELLS-1:0]       rise;
  logic [1:0][1:0]        len_q, len_d;
  logic [1:0][1:0]        lives_q, lives_d;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]             invuln_q, invuln_d;
  status_e                status_q, status_d;
  logic [1:0][IDX_W-1:0]  cor;
  logic [7:0]             lfsr;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (bus.restart_i),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign cor = {bus.p2_cor_i, bus.p1_cor_i};

  // Next-state: restart reloads everything; a finished game freezes the map and players.
  always_comb begin
    wall_d   = wall_q;
    pu_d     = pu_q;
    prev_d   = bus.explode_i;
    len_d    = len_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    rise     = bus.explode_i & ~prev_q;

    for (int p = 0; p < 2; p++)
      if (cnt_q[p] != '0) cnt_d[p] = cnt_q[p] - CNT_W'(1);

    if (bus.restart_i) begin
      wall_d   = WALL_INIT;
      pu_d     = '0;
      prev_d   = '0;
      len_d    = '0;
      lives_d  = {2{2'(LIVES)}};
      cnt_d    = '0;
      status_d = NOT_OVER;
    end else if (status_q == NOT_OVER) begin
      for (int i = 0; i < CELLS; i++) begin
        if (rise[i]) begin
          if (wall_q[i] == ABLE_WALL) begin
            wall_d[i] = EMPTY_WALL;
            pu_d[i]   = ((lfsr ^ IDX_W'(i)) & {6'd0, DROP_MASK}) == 8'd0;
          end else if (wall_q[i] == EMPTY_WALL && pu_q[i]) begin
            pu_d[i] = 1'b0;
          end
        end
      end

      // Player 1 wins a shared pickup; a rising blast on the cell takes priority.
      for (int p = 0; p < 2; p++) begin
        if (pu_q[cor[p]] && !rise[cor[p]] && !(p == 1 && cor[1] == cor[0])) begin
          pu_d[cor[p]] = 1'b0;
          if (len_q[p] != 2'd3) len_d[p] = len_q[p] + 2'd1;
        end
        if (bus.explode_i[cor[p]] && cnt_q[p] == '0) begin
          lives_d[p] = lives_q[p] - 2'd1;
          cnt_d[p]   = CNT_W'(INVULN_TICKS);
        end
      end

      if (lives_d[0] == 2'd0 && lives_d[1] == 2'd0) status_d = GAME_OVER;
      else if (lives_d[0] == 2'd0)                  status_d = P2_WIN;
      else if (lives_d[1] == 2'd0)                  status_d = P1_WIN;
    end

    invuln_d = {cnt_d[1] != '0, cnt_d[0] != '0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wall_q   <= WALL_INIT;
      pu_q     <= '0;
      prev_q   <= '0;
      len_q    <= '0;
      lives_q  <= {2{2'(LIVES)}};
      cnt_q    <= '0;
      invuln_q <= '0;
      status_q <= NOT_OVER;
    end else begin
      wall_q   <= wall_d;
      pu_q     <= pu_d;
      prev_q   <= prev_d;
      len_q    <= len_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      invuln_q <= invuln_d;
      status_q <= status_d;
    end
  end

  assign bus.wall_grid_o    = wall_q;
  assign bus.powerup_grid_o = pu_q;
  assign bus.p1_bomb_len_o  = len_q[0];
  assign bus.p2_bomb_len_o  = len_q[1];
  assign bus.p1_lives_o     = lives_q[0];
  assign bus.p2_lives_o     = lives_q[1];
  assign bus.p1_invuln_o    = invuln_q[0];
  assign bus.p2_invuln_o    = invuln_q[1];
  assign bus.game_status_o  = status_q;

endmodule

// File: tb/tb_blast_resolver.sv
// Directed and randomized checks of blast_resolver against a cell-level behavioural model.
module tb_blast_resolver;

  localparam int         M_LIVES = 3;
  localparam int         M_INV   = 60;
  localparam logic [7:0] M_SEED  = 8'hA5;
  localparam logic [7:0] M_DROP  = 8'h03;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  blast_resolver_if bus ();

  blast_resolver #(
    .LIVES        (M_LIVES),
    .INVULN_TICKS (M_INV),
    .DROP_MASK    (2'b11),
    .LFSR_SEED    (M_SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model state
  int         m_wall  [256];
  bit         m_pu    [256];
  bit         m_prev  [256];
  int         m_len   [2];
  int         m_lives [2];
  int         m_cnt   [2];
  int         m_status;
  logic [7:0] m_lfsr;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic int ref_wall(input int i);
    int r, c;
    r = i / 16;
    c = i % 16;
    if (i == 17 || i == 18 || i == 33 || i == 238 || i == 237 || i == 222) return 0;
    if (r == 0 || r == 15 || c == 0 || c == 15) return 2;
    if (r % 2 == 0 && c % 2 == 0) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_wall[i] = ref_wall(i);
      m_pu[i]   = 1'b0;
      m_prev[i] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      m_len[p]   = 0;
      m_lives[p] = M_LIVES;
      m_cnt[p]   = 0;
    end
    m_status = 0;
    m_lfsr   = M_SEED;
  endtask

  task automatic model_step(input bit rs, input logic [255:0] ex, input int c1, input int c2);
    bit rise [256];
    bit npu  [256];
    int cor  [2];
    if (rs) begin
      model_reset();
      return;
    end
    cor[0] = c1;
    cor[1] = c2;
    for (int i = 0; i < 256; i++) begin
      rise[i] = ex[i] && !m_prev[i];
      npu[i]  = m_pu[i];
    end
    if (m_status == 0) begin
      for (int i = 0; i < 256; i++) begin
        if (rise[i] && m_wall[i] == 1) begin
          m_wall[i] = 0;
          npu[i]    = (((m_lfsr ^ 8'(i)) & M_DROP) == 8'd0);
        end else if (rise[i] && m_wall[i] == 0 && m_pu[i]) begin
          npu[i] = 1'b0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!(p == 1 && cor[1] == cor[0]) && m_pu[cor[p]] && !rise[cor[p]]) begin
          npu[cor[p]] = 1'b0;
          m_len[p]    = (m_len[p] < 3) ? m_len[p] + 1 : 3;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (ex[cor[p]] && m_cnt[p] == 0) begin
          m_lives[p] = m_lives[p] - 1;
          m_cnt[p]   = M_INV;
        end else if (m_cnt[p] > 0) begin
          m_cnt[p] = m_cnt[p] - 1;
        end
      end
      if (m_lives[0] == 0 && m_lives[1] == 0) m_status = 1;
      else if (m_lives[0] == 0)               m_status = 3;
      else if (m_lives[1] == 0)               m_status = 2;
    end else begin
      for (int p = 0; p < 2; p++) if (m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
    end
    m_pu = npu;
    for (int i = 0; i < 256; i++) m_prev[i] = ex[i];
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int bad_w, bad_p;
      bad_w = -1;
      bad_p = -1;
      for (int i = 0; i < 256; i++) begin
        if (bad_w < 0 && int'(bus.wall_grid_o[i]) != m_wall[i]) bad_w = i;
        if (bad_p < 0 && int'(bus.powerup_grid_o[i]) != int'(m_pu[i])) bad_p = i;
      end
      n_vec++;
      if (bad_w >= 0) begin
        n_err++;
        $display("FAIL wall_grid cell %0d: got %0d expected %0d at %0t",
                 bad_w, bus.wall_grid_o[bad_w], m_wall[bad_w], $time);
      end
      n_vec++;
      if (bad_p >= 0) begin
        n_err++;
        $display("FAIL powerup_grid cell %0d: got %0d expected %0d at %0t",
                 bad_p, bus.powerup_grid_o[bad_p], m_pu[bad_p], $time);
      end
      check("p1_bomb_len", int'(bus.p1_bomb_len_o), m_len[0]);
      check("p2_bomb_len", int'(bus.p2_bomb_len_o), m_len[1]);
      check("p1_lives",    int'(bus.p1_lives_o),    m_lives[0]);
      check("p2_lives",    int'(bus.p2_lives_o),    m_lives[1]);
      check("p1_invuln",   int'(bus.p1_invuln_o),   int'(m_cnt[0] != 0));
      check("p2_invuln",   int'(bus.p2_invuln_o),   int'(m_cnt[1] != 0));
      check("game_status", int'(bus.game_status_o), m_status);
    end
  end

  task automatic step(input logic [255:0] ex, input int c1, input int c2, input bit rs);
    bus.explode_i = ex;
    bus.p1_cor_i  = 8'(c1);
    bus.p2_cor_i  = 8'(c2);
    bus.restart_i = rs;
    @(posedge clk);
    model_step(rs, ex, c1, c2);
    @(negedge clk);
  endtask

  function automatic int pick_cell();
    int s;
    s = int'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 0)
      for (int k = 0; k < 256; k++) if (m_pu[(s + k) % 256]) return (s + k) % 256;
    return s;
  endfunction

  initial begin
    logic [255:0] ex;
    logic [255:0] rex;
    int c1, c2;

    reset         = 1'b1;
    bus.restart_i = 1'b0;
    bus.explode_i = '0;
    bus.p1_cor_i  = 8'd17;
    bus.p2_cor_i  = 8'd238;
    model_reset();
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    check("rst_wall19", int'(bus.wall_grid_o[19]), 1);
    check("rst_wall34", int'(bus.wall_grid_o[34]), 2);
    check("rst_wall18", int'(bus.wall_grid_o[18]), 0);
    check("rst_wall0",  int'(bus.wall_grid_o[0]),  2);
    check("rst_lives",  int'({bus.p1_lives_o, bus.p2_lives_o}), 4'hF);
    check("rst_status", int'(bus.game_status_o), 0);

    // LFSR A5: cell 19 destroyed, no drop
    ex = '0; ex[19] = 1'b1;
    step(ex, 17, 238, 1'b0);
    check("burn19_wall", int'(bus.wall_grid_o[19]), 0);
    check("burn19_pu",   int'(bus.powerup_grid_o[19]), 0);
    // LFSR 4A: cell 22 destroyed and drops
    ex[22] = 1'b1;
    step(ex, 17, 238, 1'b0);
    check("burn22_wall", int'(bus.wall_grid_o[22]), 0);
    check("burn22_pu",   int'(bus.powerup_grid_o[22]), 1);
    ex = '0; ex[19] = 1'b1; ex[34] = 1'b1;
    step(ex, 17, 238, 1'b0);
    check("sustain19_pu", int'(bus.powerup_grid_o[19]), 0);
    check("unable34",     int'(bus.wall_grid_o[34]), 2);
    // Both players on the power-up: only player 1 collects
    step('0, 22, 22, 1'b0);
    check("share_pu",   int'(bus.powerup_grid_o[22]), 0);
    check("share_len1", int'(bus.p1_bomb_len_o), 1);
    check("share_len2", int'(bus.p2_bomb_len_o), 0);

    // Lingering blast on player 1
    ex = '0; ex[17] = 1'b1;
    for (int t = 0; t < 70; t++) begin
      step(ex, 17, 238, 1'b0);
      if (t == 0)  check("hit_t1_lives",    int'(bus.p1_lives_o), 2);
      if (t == 0)  check("hit_t1_inv",      int'(bus.p1_invuln_o), 1);
      if (t == 59) check("hit_t60_inv",     int'(bus.p1_invuln_o), 1);
      if (t == 60) check("hit_t61_inv",     int'(bus.p1_invuln_o), 0);
      if (t == 60) check("hit_t61_lives",   int'(bus.p1_lives_o), 2);
      if (t == 61) check("hit_t62_lives",   int'(bus.p1_lives_o), 1);
    end

    // Player 2 dies: player 1 wins
    ex = '0; ex[238] = 1'b1;
    for (int t = 0; t < 130; t++) begin
      step(ex, 17, 238, 1'b0);
      if (t == 121) check("p2die_pre", int'(bus.game_status_o), 0);
      if (t == 122) check("p2die_st",  int'(bus.game_status_o), 2);
    end
    ex = '0; ex[17] = 1'b1; ex[21] = 1'b1;
    repeat (3) step(ex, 17, 238, 1'b0);
    check("frz_wall21", int'(bus.wall_grid_o[21]), 1);
    check("frz_lives1", int'(bus.p1_lives_o), 1);

    // Restart mid-blast, then the held explode fires one tick later
    ex = '0; ex[21] = 1'b1;
    step(ex, 17, 238, 1'b1);
    check("rs_wall21", int'(bus.wall_grid_o[21]), 1);
    check("rs_wall22", int'(bus.wall_grid_o[22]), 1);
    check("rs_lives",  int'({bus.p1_lives_o, bus.p2_lives_o}), 4'hF);
    check("rs_len",    int'(bus.p1_bomb_len_o), 0);
    check("rs_status", int'(bus.game_status_o), 0);
    step(ex, 17, 238, 1'b0);
    check("rs_rise21", int'(bus.wall_grid_o[21]), 0);
    check("rs_drop21", int'(bus.powerup_grid_o[21]), 1);

    // Simultaneous final hits: draw
    ex = '0; ex[17] = 1'b1; ex[238] = 1'b1;
    for (int t = 0; t < 130; t++) begin
      step(ex, 17, 238, 1'b0);
      if (t == 122) check("draw_st", int'(bus.game_status_o), 1);
    end

    step('0, 17, 238, 1'b1);
    rex = '0;
    c1  = 17;
    c2  = 238;
    for (int n = 0; n < 4000; n++) begin
      bit rs;
      rs = ($urandom_range(0, 299) == 0) || (m_status != 0 && $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) c1 = pick_cell();
      if ($urandom_range(0, 7) == 0) c2 = ($urandom_range(0, 9) == 0) ? c1 : pick_cell();
      if ($urandom_range(0, 3) == 0) begin
        rex = '0;
        repeat ($urandom_range(0, 5)) rex[$urandom_range(0, 255)] = 1'b1;
        if ($urandom_range(0, 2) == 0) rex[c1] = 1'b1;
        if ($urandom_range(0, 2) == 0) rex[c2] = 1'b1;
      end
      step(rex, c1, c2, rs);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
